// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the parametrised SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Top-level frame sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DATA_W_MAX = 32;
  localparam int IDX_W      = $clog2(DATA_W_MAX);

  // Reverse the low w bits of v; bits at and above w come back as zero.
  // Used to present LSB-first frames to an MSB-first shift register.
  function automatic logic [DATA_W_MAX-1:0] bit_rev(input logic [DATA_W_MAX-1:0] v,
                                                    input int w);
    logic [DATA_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W_MAX; i++) begin
      if (i < w) r[IDX_W'(i)] = v[IDX_W'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_param_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sck_gen
// Description : Half-period strobe counter and SCK toggle flop for the SPI
//               master. SCK is an ordinary register in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,     // frame in progress
  input  logic             tog,    // toggle SCK on tick (data phase only)
  input  logic [DIV_W-1:0] div,    // half period = div+1 clk cycles
  input  logic             cpol,   // idle level, tracked while not enabled
  output logic             tick,
  output logic             sck
);

  logic [DIV_W-1:0] cnt_q;
  logic             sck_q;

  assign tick = en && (cnt_q == div);
  assign sck  = sck_q;

  // Half-period counter plus SCK flop; idle SCK follows cpol one cycle late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      sck_q <= cpol;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
      if (tick && tog) sck_q <= ~sck_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_param
// Description : Parametrised SPI master: CPOL/CPHA modes, MSB/LSB first,
//               runtime clock divider, one-hot active-low chip selects.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_SS = 4,
  parameter  int DIV_W  = 12,
  localparam int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int                ECNT_W    = $clog2(2 * DATA_W) + 1;
  localparam logic [ECNT_W-1:0] LAST_EDGE = ECNT_W'(2 * DATA_W - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sh_q;
  logic [DATA_W-1:0]   rx_q;
  logic [ECNT_W-1:0]   edge_q;
  logic [DIV_W-1:0]    div_q;
  logic [NUM_SS-1:0]   ss_n_q;
  logic                cpha_q;
  logic                lsb_q;
  logic                mosi_q;
  logic                done_q;

  logic                w_tick;
  logic                w_accept;
  logic                w_lead;
  logic                w_last;
  logic                w_sample;
  logic                w_shift;
  logic [DATA_W-1:0]   w_tx_m;
  logic [DATA_W-1:0]   w_rx_m;
  logic [NUM_SS-1:0]   w_ss_dec;

  assign w_accept = (state_q == IDLE) && start;
  assign w_lead   = ~edge_q[0];
  assign w_last   = (edge_q == LAST_EDGE);
  // cpha=0 samples on leading edges, cpha=1 on trailing; the other edge shifts.
  // The final trailing edge in cpha=0 has no further bit to present.
  assign w_sample = (w_lead != cpha_q);
  assign w_shift  = (w_lead == cpha_q) && !w_last;

  // The shift register is always MSB-first; LSB-first frames are reversed on load/unload
  assign w_tx_m = lsb_first ? DATA_W'(bit_rev(DATA_W_MAX'(tx_data), DATA_W)) : tx_data;
  assign w_rx_m = lsb_q     ? DATA_W'(bit_rev(DATA_W_MAX'(sh_q), DATA_W))    : sh_q;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rx_data = rx_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

  spi_sck_gen #(.DIV_W(DIV_W)) u_sck_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q != IDLE),
    .tog   (state_q == XFER),
    .div   (div_q),
    .cpol  (cpol),
    .tick  (w_tick),
    .sck   (sck)
  );

  // One-hot active-low decode of the requested slave; out-of-range selects none
  always_comb begin
    w_ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SEL_W'(i)) w_ss_dec[i] = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: each phase lasts whole half periods, ended by a tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)            state_d = SETUP;
      SETUP:   if (w_tick)           state_d = XFER;
      XFER:    if (w_tick && w_last) state_d = HOLD;
      HOLD:    if (w_tick)           state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Datapath: config latch, shift/sample on ticks, frame completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      rx_q   <= '0;
      edge_q <= '0;
      div_q  <= '0;
      ss_n_q <= '1;
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (w_accept) begin
        // First bit goes straight onto mosi; cpha=0 pre-shifts so that the
        // first leading edge can drop the sampled bit into sh_q[0].
        mosi_q <= w_tx_m[DATA_W-1];
        sh_q   <= cpha ? w_tx_m : {w_tx_m[DATA_W-2:0], 1'b0};
        edge_q <= '0;
        div_q  <= clk_div;
        cpha_q <= cpha;
        lsb_q  <= lsb_first;
        ss_n_q <= w_ss_dec;
      end else if ((state_q == XFER) && w_tick) begin
        edge_q <= edge_q + ECNT_W'(1);
        if (w_sample) sh_q[0] <= miso;
        if (w_shift) begin
          mosi_q <= sh_q[DATA_W-1];
          sh_q   <= {sh_q[DATA_W-2:0], 1'b0};
        end
      end else if ((state_q == HOLD) && w_tick) begin
        ss_n_q <= '1;
        rx_q   <= w_rx_m;
        done_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
